// File: rtl/mem_stage.sv
// Load/store stage: decodes memory ops, drives a req/ack data bus with byte enables,
// extends load data and reports misaligned accesses and bus timeouts.
module mem_stage #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        in_valid,
  input  logic [31:0] Ins,
  input  logic [31:0] Result,
  input  logic [31:0] Rdata2,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        out_valid,
  output logic [31:0] WbData,
  output logic        addr_err,
  output logic        bus_err
);

  typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [5:0]       op_reg, op_next;
  logic [1:0]       lo_reg, lo_next;
  logic             we_reg, we_next;
  logic [31:0]      addr_reg, addr_next;
  logic [3:0]       be_reg, be_next;
  logic [31:0]      wdata_reg, wdata_next;
  logic             out_valid_reg, out_valid_next;
  logic [31:0]      wb_reg, wb_next;
  logic             addr_err_reg, addr_err_next;
  logic             bus_err_reg, bus_err_next;

  logic [5:0]  opcode;
  logic        is_mem, is_store;
  logic [1:0]  size;
  logic        misaligned;
  logic [3:0]  be_calc;
  logic [31:0] wdata_calc;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_val;
  logic        unused_ins;

  assign opcode     = Ins[31:26];
  assign unused_ins = ^Ins[25:0];

  always_comb begin
    is_mem   = 1'b1;
    is_store = 1'b0;
    size     = SZ_WORD;
    case (opcode)
      6'h20, 6'h24: size = SZ_BYTE;
      6'h21, 6'h25: size = SZ_HALF;
      6'h23:        size = SZ_WORD;
      6'h28: begin size = SZ_BYTE; is_store = 1'b1; end
      6'h29: begin size = SZ_HALF; is_store = 1'b1; end
      6'h2B: begin size = SZ_WORD; is_store = 1'b1; end
      default: is_mem = 1'b0;
    endcase
  end

  assign misaligned = ((size == SZ_HALF) && Result[0]) ||
                      ((size == SZ_WORD) && (Result[1:0] != 2'b00));

  always_comb begin
    be_calc    = 4'b1111;
    wdata_calc = Rdata2;
    case (size)
      SZ_BYTE: begin
        be_calc    = 4'b0001 << Result[1:0];
        wdata_calc = {4{Rdata2[7:0]}};
      end
      SZ_HALF: begin
        be_calc    = 4'b0011 << Result[1:0];
        wdata_calc = {2{Rdata2[15:0]}};
      end
      default: ;
    endcase
  end

  // Lane selection uses the offset captured at accept time, not the live Result.
  always_comb begin
    rd_byte = dmem_rdata[7:0];
    case (lo_reg)
      2'd1:    rd_byte = dmem_rdata[15:8];
      2'd2:    rd_byte = dmem_rdata[23:16];
      2'd3:    rd_byte = dmem_rdata[31:24];
      default: ;
    endcase
    rd_half  = lo_reg[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    load_val = dmem_rdata;
    case (op_reg)
      6'h20:   load_val = {{24{rd_byte[7]}}, rd_byte};
      6'h24:   load_val = {24'd0, rd_byte};
      6'h21:   load_val = {{16{rd_half[15]}}, rd_half};
      6'h25:   load_val = {16'd0, rd_half};
      default: ;
    endcase
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    op_next        = op_reg;
    lo_next        = lo_reg;
    we_next        = we_reg;
    addr_next      = addr_reg;
    be_next        = be_reg;
    wdata_next     = wdata_reg;
    out_valid_next = 1'b0;
    wb_next        = wb_reg;
    addr_err_next  = 1'b0;
    bus_err_next   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          if (!is_mem) begin
            out_valid_next = 1'b1;
            wb_next        = Result;
          end else if (misaligned) begin
            out_valid_next = 1'b1;
            addr_err_next  = 1'b1;
            wb_next        = 32'd0;
          end else begin
            state_next = REQ;
            cnt_next   = '0;
            op_next    = opcode;
            lo_next    = Result[1:0];
            we_next    = is_store;
            addr_next  = {Result[31:2], 2'b00};
            be_next    = be_calc;
            wdata_next = wdata_calc;
          end
        end
      end
      REQ: begin
        // An ack in the final counted cycle still completes normally.
        if (dmem_ack) begin
          state_next     = IDLE;
          out_valid_next = 1'b1;
          wb_next        = we_reg ? 32'd0 : load_val;
        end else if (cnt_reg == CNT_LAST) begin
          state_next     = IDLE;
          out_valid_next = 1'b1;
          bus_err_next   = 1'b1;
          wb_next        = 32'd0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      op_reg        <= '0;
      lo_reg        <= '0;
      we_reg        <= 1'b0;
      addr_reg      <= '0;
      be_reg        <= '0;
      wdata_reg     <= '0;
      out_valid_reg <= 1'b0;
      wb_reg        <= '0;
      addr_err_reg  <= 1'b0;
      bus_err_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      op_reg        <= op_next;
      lo_reg        <= lo_next;
      we_reg        <= we_next;
      addr_reg      <= addr_next;
      be_reg        <= be_next;
      wdata_reg     <= wdata_next;
      out_valid_reg <= out_valid_next;
      wb_reg        <= wb_next;
      addr_err_reg  <= addr_err_next;
      bus_err_reg   <= bus_err_next;
    end
  end

  assign stall      = (state_reg == REQ);
  assign dmem_req   = (state_reg == REQ);
  assign dmem_we    = we_reg;
  assign dmem_addr  = addr_reg;
  assign dmem_be    = be_reg;
  assign dmem_wdata = wdata_reg;
  assign out_valid  = out_valid_reg;
  assign WbData     = wb_reg;
  assign addr_err   = addr_err_reg;
  assign bus_err    = bus_err_reg;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage (TIMEOUT=4): table of single transactions plus
// hand-written reset-during-REQ and back-to-back sequences.
module tb_mem_stage;

  logic        CLK = 1'b0;
  logic        RST;
  logic        in_valid;
  logic [31:0] Ins, Result, Rdata2;
  logic        stall, dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        out_valid;
  logic [31:0] WbData;
  logic        addr_err, bus_err;

  mem_stage #(.TIMEOUT(4), .CNT_W(3)) dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .Ins(Ins), .Result(Result),
    .Rdata2(Rdata2), .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .out_valid(out_valid),
    .WbData(WbData), .addr_err(addr_err), .bus_err(bus_err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string       name;
    logic [31:0] ins, result, rdata2, rdata;
    int          ack_at;      // REQ cycle index carrying ack, -1 = never
    bit          exp_req, exp_we, chk_wdata;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata, exp_wb;
    int          exp_cycles;
    bit          exp_ae, exp_berr;
  } vec_t;

  int total = 0;
  int passed = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  localparam logic [31:0] I_LB  = 32'h8000_0000;
  localparam logic [31:0] I_LH  = 32'h8400_0000;
  localparam logic [31:0] I_LW  = 32'h8C00_0000;
  localparam logic [31:0] I_LBU = 32'h9000_0000;
  localparam logic [31:0] I_LHU = 32'h9400_0000;
  localparam logic [31:0] I_SB  = 32'hA000_0000;
  localparam logic [31:0] I_SH  = 32'hA400_0000;
  localparam logic [31:0] I_SW  = 32'hAC00_0000;
  localparam logic [31:0] I_ADD = 32'h0000_0021;
  localparam logic [31:0] I_X22 = 32'h8800_0000;

  vec_t vecs[15];

  initial begin
    //           name      ins    result        rdata2        rdata         ack req we wd addr          be       wdata         wb            cyc ae be
    vecs[0]  = '{"lw",     I_LW,  32'h100,      32'h0,        32'hDEADBEEF, 0,  1, 0, 0, 32'h100,     4'b1111, 32'h0,        32'hDEADBEEF, 1, 0, 0};
    vecs[1]  = '{"lb",     I_LB,  32'h103,      32'h0,        32'h80123456, 0,  1, 0, 0, 32'h100,     4'b1000, 32'h0,        32'hFFFFFF80, 1, 0, 0};
    vecs[2]  = '{"lbu",    I_LBU, 32'h103,      32'h0,        32'h80123456, 0,  1, 0, 0, 32'h100,     4'b1000, 32'h0,        32'h00000080, 1, 0, 0};
    vecs[3]  = '{"lh",     I_LH,  32'h102,      32'h0,        32'h80123456, 0,  1, 0, 0, 32'h100,     4'b1100, 32'h0,        32'hFFFF8012, 1, 0, 0};
    vecs[4]  = '{"lhu",    I_LHU, 32'h100,      32'h0,        32'h80123456, 0,  1, 0, 0, 32'h100,     4'b0011, 32'h0,        32'h00003456, 1, 0, 0};
    vecs[5]  = '{"lb_ws",  I_LB,  32'h101,      32'h0,        32'h80123456, 2,  1, 0, 0, 32'h100,     4'b0010, 32'h0,        32'h00000034, 3, 0, 0};
    vecs[6]  = '{"sh",     I_SH,  32'h102,      32'h0000ABCD, 32'h0,        1,  1, 1, 1, 32'h100,     4'b1100, 32'hABCDABCD, 32'h0,        2, 0, 0};
    vecs[7]  = '{"sb",     I_SB,  32'h101,      32'h123456EF, 32'h0,        0,  1, 1, 1, 32'h100,     4'b0010, 32'hEFEFEFEF, 32'h0,        1, 0, 0};
    vecs[8]  = '{"sw",     I_SW,  32'h200,      32'hCAFEF00D, 32'h0,        0,  1, 1, 1, 32'h200,     4'b1111, 32'hCAFEF00D, 32'h0,        1, 0, 0};
    vecs[9]  = '{"addu",   I_ADD, 32'h55,       32'h0,        32'h0,        0,  0, 0, 0, 32'h0,       4'b0000, 32'h0,        32'h00000055, 0, 0, 0};
    vecs[10] = '{"lw_mis", I_LW,  32'h101,      32'h0,        32'h0,        0,  0, 0, 0, 32'h0,       4'b0000, 32'h0,        32'h0,        0, 1, 0};
    vecs[11] = '{"op22",   I_X22, 32'hAAAA5555, 32'h0,        32'h0,        0,  0, 0, 0, 32'h0,       4'b0000, 32'h0,        32'hAAAA5555, 0, 0, 0};
    vecs[12] = '{"lh_mis", I_LH,  32'h103,      32'h0,        32'h0,        0,  0, 0, 0, 32'h0,       4'b0000, 32'h0,        32'h0,        0, 1, 0};
    vecs[13] = '{"tmo",    I_LW,  32'h300,      32'h0,        32'h0,        -1, 1, 0, 0, 32'h300,     4'b1111, 32'h0,        32'h0,        4, 0, 1};
    vecs[14] = '{"ack_lst",I_LW,  32'h300,      32'h0,        32'h11223344, 3,  1, 0, 0, 32'h300,     4'b1111, 32'h0,        32'h11223344, 4, 0, 0};
  end

  initial begin
    RST = 1'b1; in_valid = 1'b0; Ins = '0; Result = '0; Rdata2 = '0;
    dmem_ack = 1'b0; dmem_rdata = '0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_req", {31'd0, dmem_req}, 32'd0);
    chk("rst_ov", {31'd0, out_valid}, 32'd0);
    chk("rst_wb", WbData, 32'd0);
    chk("rst_addr", dmem_addr, 32'd0);
    chk("rst_be", {28'd0, dmem_be}, 32'd0);
    chk("rst_errs", {30'd0, addr_err, bus_err}, 32'd0);
    RST = 1'b0;

    for (int i = 0; i < 15; i++) begin
      int  n;
      bit  done;
      @(negedge CLK);
      Ins = vecs[i].ins; Result = vecs[i].result; Rdata2 = vecs[i].rdata2;
      dmem_rdata = vecs[i].rdata; in_valid = 1'b1;
      @(posedge CLK); #1;
      in_valid = 1'b0;
      if (vecs[i].exp_req) begin
        chk({vecs[i].name, "_req"}, {31'd0, dmem_req}, 32'd1);
        chk({vecs[i].name, "_stall"}, {31'd0, stall}, 32'd1);
        chk({vecs[i].name, "_addr"}, dmem_addr, vecs[i].exp_addr);
        chk({vecs[i].name, "_be"}, {28'd0, dmem_be}, {28'd0, vecs[i].exp_be});
        chk({vecs[i].name, "_we"}, {31'd0, dmem_we}, {31'd0, vecs[i].exp_we});
        if (vecs[i].chk_wdata) chk({vecs[i].name, "_wdata"}, dmem_wdata, vecs[i].exp_wdata);
        n = 0; done = 0;
        while (!done && n < 20) begin
          dmem_ack = (n == vecs[i].ack_at);
          @(posedge CLK); #1;
          dmem_ack = 1'b0;
          n++;
          if (!dmem_req) done = 1;
          else chk({vecs[i].name, "_addr_hold"}, dmem_addr, vecs[i].exp_addr);
        end
        chk({vecs[i].name, "_req_cycles"}, n, vecs[i].exp_cycles);
      end else begin
        chk({vecs[i].name, "_no_req"}, {31'd0, dmem_req}, 32'd0);
      end
      chk({vecs[i].name, "_ov"}, {31'd0, out_valid}, 32'd1);
      chk({vecs[i].name, "_wb"}, WbData, vecs[i].exp_wb);
      chk({vecs[i].name, "_addr_err"}, {31'd0, addr_err}, {31'd0, vecs[i].exp_ae});
      chk({vecs[i].name, "_bus_err"}, {31'd0, bus_err}, {31'd0, vecs[i].exp_berr});
      chk({vecs[i].name, "_stall_done"}, {31'd0, stall}, 32'd0);
      @(posedge CLK); #1;
      chk({vecs[i].name, "_ov_pulse"}, {31'd0, out_valid}, 32'd0);
      chk({vecs[i].name, "_err_pulse"}, {30'd0, addr_err, bus_err}, 32'd0);
      chk({vecs[i].name, "_wb_hold"}, WbData, vecs[i].exp_wb);
      $display("vec %0d %s: wb=%h ae=%0d be=%0d", i, vecs[i].name, vecs[i].exp_wb, vecs[i].exp_ae, vecs[i].exp_berr);
    end

    // Reset in the second REQ cycle, then a stray ack once back in IDLE.
    @(negedge CLK);
    Ins = I_LW; Result = 32'h400; dmem_rdata = 32'h99999999; in_valid = 1'b1;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    chk("rstreq_req1", {31'd0, dmem_req}, 32'd1);
    @(posedge CLK); #1;
    chk("rstreq_req2", {31'd0, dmem_req}, 32'd1);
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    chk("rstreq_req_drop", {31'd0, dmem_req}, 32'd0);
    chk("rstreq_stall", {31'd0, stall}, 32'd0);
    chk("rstreq_ov", {31'd0, out_valid}, 32'd0);
    dmem_ack = 1'b1;
    @(posedge CLK); #1;
    dmem_ack = 1'b0;
    chk("late_ack_ov", {31'd0, out_valid}, 32'd0);
    chk("late_ack_req", {31'd0, dmem_req}, 32'd0);
    $display("seq reset_during_req done");

    // Back-to-back: accept a load while the previous op's out_valid pulses;
    // in_valid during REQ must be ignored.
    @(negedge CLK);
    Ins = I_ADD; Result = 32'h11; in_valid = 1'b1;
    @(posedge CLK); #1;
    Ins = I_LW; Result = 32'h100; dmem_rdata = 32'h5A5A5A5A;
    chk("b2b_ov1", {31'd0, out_valid}, 32'd1);
    chk("b2b_wb1", WbData, 32'h11);
    @(posedge CLK); #1;
    Ins = I_ADD; Result = 32'h77;
    chk("b2b_req", {31'd0, dmem_req}, 32'd1);
    chk("b2b_ov_gap", {31'd0, out_valid}, 32'd0);
    dmem_ack = 1'b1;
    @(posedge CLK); #1;
    dmem_ack = 1'b0; in_valid = 1'b0;
    chk("b2b_ov2", {31'd0, out_valid}, 32'd1);
    chk("b2b_wb2", WbData, 32'h5A5A5A5A);
    @(posedge CLK); #1;
    chk("b2b_ignored", {31'd0, out_valid}, 32'd0);
    chk("b2b_wb_hold", WbData, 32'h5A5A5A5A);
    $display("seq back_to_back done");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
